// File: rtl/register_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// register_file_param
//
// Parameterised general-purpose register file with two registered read ports,
// one sized write port and a banked stack pointer at the top address.
// After reset an INIT sequence clears one location per cycle (indices
// 0..NUM_REGS-2, then USP, then SSP) before the file accepts writes.
//
// Build option:
//   REGFILE_BYPASS_EN  defined   -> write-first: a read that hits a same-cycle
//                                   accepted write returns the merged write value
//                      undefined -> read-first: that read returns the old value
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | clearing storage; reads return 0, writes rejected (wr_err)
//   ST_RUN  | normal operation; init_done high
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   init_done  out  high once the clear sequence has completed
//   rd_a_addr  in   read port A address
//   rd_a_data  out  read port A data (registered, 1-cycle latency)
//   rd_b_addr  in   read port B address
//   rd_b_data  out  read port B data (registered, 1-cycle latency)
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_size    in   3'b001 byte [7:0], 3'b010 word [15:0], 3'b100 long
//   wr_data    in   write data
//   sp_sel     in   top address maps to USP (0) or SSP (1)
//   usp        out  current user stack pointer (registered)
//   wr_err     out  one-cycle pulse for a rejected write
//
// Parameters: DATA_W multiple of 16 (>=16), NUM_REGS power of two (>=4),
// ADDR_W = log2(NUM_REGS).
// -----------------------------------------------------------------------------
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_size,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sp_sel,
  output logic [DATA_W-1:0] usp,
  output logic              wr_err
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_USP = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  CNT_SSP = CNT_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic [DATA_W-1:0] usp_q, usp_d;
  logic [DATA_W-1:0] ssp_q, ssp_d;

  // General-purpose storage; the top address lives in usp_q/ssp_q instead.
  logic [DATA_W-1:0] regs_q [0:NUM_REGS-2];

  logic              size_ok;
  logic              wr_accept;
  logic              wr_is_sp;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_a_raw, rd_b_raw;
  logic [DATA_W-1:0] rd_a_val, rd_b_val;

  assign size_ok   = (wr_size == 3'b001) || (wr_size == 3'b010) || (wr_size == 3'b100);
  assign wr_accept = wr_en && size_ok && (state_q == ST_RUN);
  assign wr_is_sp  = (wr_addr == SP_ADDR);

  always_comb begin
    wr_old = '0;
    if (wr_is_sp) begin
      wr_old = sp_sel ? ssp_q : usp_q;
    end else begin
      wr_old = regs_q[wr_addr];
    end
  end

  // Partial writes merge into the current contents of the addressed location.
  always_comb begin
    wr_merged = wr_old;
    if (wr_size[0]) begin
      wr_merged[7:0] = wr_data[7:0];
    end else if (wr_size[1]) begin
      wr_merged[15:0] = wr_data[15:0];
    end else if (wr_size[2]) begin
      wr_merged = wr_data;
    end
  end

  always_comb begin
    rd_a_raw = '0;
    if (rd_a_addr == SP_ADDR) begin
      rd_a_raw = sp_sel ? ssp_q : usp_q;
    end else begin
      rd_a_raw = regs_q[rd_a_addr];
    end
  end

  always_comb begin
    rd_b_raw = '0;
    if (rd_b_addr == SP_ADDR) begin
      rd_b_raw = sp_sel ? ssp_q : usp_q;
    end else begin
      rd_b_raw = regs_q[rd_b_addr];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // sp_sel is shared by reads and the write, so an address match at the top
  // address already implies the same USP/SSP bank.
  assign rd_a_val = (wr_accept && (rd_a_addr == wr_addr)) ? wr_merged : rd_a_raw;
  assign rd_b_val = (wr_accept && (rd_b_addr == wr_addr)) ? wr_merged : rd_b_raw;
`else
  assign rd_a_val = rd_a_raw;
  assign rd_b_val = rd_b_raw;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_a_d      = '0;
    rd_b_d      = '0;
    usp_d       = usp_q;
    ssp_d       = ssp_q;
    wr_err_d    = wr_en && !wr_accept;

    case (state_q)
      ST_INIT: begin
        init_done_d = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_USP) begin
          usp_d = '0;
        end
        if (cnt_q == CNT_SSP) begin
          ssp_d       = '0;
          cnt_d       = '0;
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        rd_a_d      = rd_a_val;
        rd_b_d      = rd_b_val;
        if (wr_accept && wr_is_sp) begin
          if (sp_sel) begin
            ssp_d = wr_merged;
          end else begin
            usp_d = wr_merged;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      usp_q       <= '0;
      ssp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      wr_err_q    <= wr_err_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      usp_q       <= usp_d;
      ssp_q       <= ssp_d;
    end
  end

  // Storage array carries no reset; INIT clears it after every reset.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      if (cnt_q < CNT_USP) begin
        regs_q[cnt_q[ADDR_W-1:0]] <= '0;
      end
    end else if (wr_accept && !wr_is_sp) begin
      regs_q[wr_addr] <= wr_merged;
    end
  end

  assign init_done = init_done_q;
  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;
  assign usp       = usp_q;
  assign wr_err    = wr_err_q;

endmodule
